// File: rtl/multdiv_mult_seq.sv
// Sequential 32x32 signed multiplier: radix-2 Booth, one iteration per clock.
// addmodule_all32 is the shared 32-bit adder; multdiv_mult_seq is the top.

module addmodule_all32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_cin};
endmodule

module multdiv_mult_seq (
    input  logic        clock,
    input  logic        resetn,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [5:0]  r_count;
    logic [31:0] r_mcand;
    logic [31:0] r_acc;
    logic [31:0] r_mplr;
    logic        r_q1;
    logic [31:0] r_result;
    logic        r_exc;
    logic        r_rdy;
    logic        r_busy;

    logic [1:0]  w_pair;
    logic [31:0] w_addend;
    logic        w_cin;
    logic [31:0] w_sum;
    logic        w_cout;
    logic        w_sign;
    logic [31:0] w_accNext;
    logic [31:0] w_mplrNext;
    logic        w_excNext;
    logic        w_lastIter;

    // State register; reset parks the machine in IDLE
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_nextState;
    end

    // Next state: a start strobe wins in every state, otherwise RUN lasts 32 cycles and DONE one
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    w_nextState = IDLE;
            RUN:     if (w_lastIter) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
        if (ctrl_MULT) w_nextState = RUN;
    end

    assign w_lastIter = (r_count == 6'd31);
    assign w_pair     = {r_mplr[0], r_q1};

    // Booth recoding: 01 adds the multiplicand, 10 subtracts it (inverted with carry-in), else adds zero
    always_comb begin
        w_addend = 32'd0;
        w_cin    = 1'b0;
        case (w_pair)
            2'b01: begin
                w_addend = r_mcand;
                w_cin    = 1'b0;
            end
            2'b10: begin
                w_addend = ~r_mcand;
                w_cin    = 1'b1;
            end
            default: begin
                w_addend = 32'd0;
                w_cin    = 1'b0;
            end
        endcase
    end

    addmodule_all32 u_adder (
        .i_a    (r_acc),
        .i_b    (w_addend),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // The bit shifted into acc[31] is the true 33-bit sign of the sum, so an INT_MIN
    // multiplicand that overflows the 32-bit add still shifts in correctly.
    assign w_sign     = r_acc[31] ^ w_addend[31] ^ w_cout;
    assign w_accNext  = {w_sign, w_sum[31:1]};
    assign w_mplrNext = {w_sum[0], r_mplr[31:1]};
    assign w_excNext  = (w_accNext != {32{w_mplrNext[31]}});

    // Datapath: load on start, one Booth step per RUN cycle, capture result on the last step
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_count  <= 6'd0;
            r_mcand  <= 32'd0;
            r_acc    <= 32'd0;
            r_mplr   <= 32'd0;
            r_q1     <= 1'b0;
            r_result <= 32'd0;
            r_exc    <= 1'b0;
        end else if (ctrl_MULT) begin
            r_count  <= 6'd0;
            r_mcand  <= data_operandA;
            r_acc    <= 32'd0;
            r_mplr   <= data_operandB;
            r_q1     <= 1'b0;
        end else if (r_state == RUN) begin
            r_acc  <= w_accNext;
            r_mplr <= w_mplrNext;
            r_q1   <= r_mplr[0];
            if (w_lastIter) begin
                r_count  <= 6'd0;
                r_result <= w_mplrNext;
                r_exc    <= w_excNext;
            end else begin
                r_count <= r_count + 6'd1;
            end
        end
    end

    // Status flags: ready pulses only for a run that completes without a restart
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rdy  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_rdy  <= (r_state == RUN) && w_lastIter && !ctrl_MULT;
            r_busy <= (w_nextState == RUN);
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;
endmodule

// File: tb/tb_multdiv_mult_seq.sv
// Testbench for multdiv_mult_seq: directed vector table, restart/reset/back-to-back
// sequences, and randomized operands checked against a plain-arithmetic product model.

module tb_multdiv_mult_seq;
    logic        clock;
    logic        resetn;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int nCompared;
    int nMismatched;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expResult;
        logic        expExc;
    } vec_t;

    vec_t vecs[11];

    multdiv_mult_seq dut (
        .clock          (clock),
        .resetn         (resetn),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    // Free-running 10 ns clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: full 64-bit signed product; overflow when the high word is not the sign extension
    function automatic logic [32:0] refMul(input logic [31:0] a, input logic [31:0] b);
        longint      p;
        logic [63:0] pv;
        p  = longint'($signed(a)) * longint'($signed(b));
        pv = p;
        return {(pv[63:32] != {32{pv[31]}}), pv[31:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Present a one-edge start strobe; returns at the falling edge after the sampling edge
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        step();
        ctrl_MULT = 1'b0;
    endtask

    task automatic waitResult(output int lat, output int busyHigh);
        lat      = -1;
        busyHigh = busy ? 1 : 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (data_resultRDY) begin
                lat = k;
                break;
            end
            if (busy) busyHigh++;
        end
    endtask

    task automatic noPulse(input string name, input int n);
        int seen;
        seen = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (data_resultRDY) seen++;
        end
        checkOutput(name, seen, 0);
    endtask

    task automatic runOp(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expRes, input logic expExc, input bit checkDrop);
        int lat;
        int busyHigh;
        applyStimulus(a, b);
        waitResult(lat, busyHigh);
        checkOutput({name, " latency"}, lat, 32);
        checkOutput({name, " busy cycles"}, busyHigh, 32);
        checkOutput({name, " busy in done"}, {31'd0, busy}, 32'd0);
        checkOutput({name, " result"}, data_result, expRes);
        checkOutput({name, " exception"}, {31'd0, data_exception}, {31'd0, expExc});
        if (checkDrop) begin
            step();
            checkOutput({name, " rdy drop"}, {31'd0, data_resultRDY}, 32'd0);
            checkOutput({name, " result hold"}, data_result, expRes);
        end
    endtask

    initial begin
        logic [32:0] exp;
        logic [31:0] ra;
        logic [31:0] rb;

        nCompared     = 0;
        nMismatched   = 0;
        resetn        = 1'b0;
        ctrl_MULT     = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;

        vecs[0]  = '{"3x5",         32'd3,          32'd5,          32'h0000000F, 1'b0};
        vecs[1]  = '{"-7x6",        32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6, 1'b0};
        vecs[2]  = '{"max x 0",     32'h7FFFFFFF,   32'd0,          32'h00000000, 1'b0};
        vecs[3]  = '{"2^16 x 2^16", 32'h00010000,   32'h00010000,   32'h00000000, 1'b1};
        vecs[4]  = '{"min x -1",    32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b1};
        vecs[5]  = '{"-1 x min",    32'hFFFFFFFF,   32'h80000000,   32'h80000000, 1'b1};
        vecs[6]  = '{"0 x 0",       32'd0,          32'd0,          32'h00000000, 1'b0};
        vecs[7]  = '{"-1 x -1",     32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 1'b0};
        vecs[8]  = '{"min x 1",     32'h80000000,   32'd1,          32'h80000000, 1'b0};
        vecs[9]  = '{"max x max",   32'h7FFFFFFF,   32'h7FFFFFFF,   32'h00000001, 1'b1};
        vecs[10] = '{"min x min",   32'h80000000,   32'h80000000,   32'h00000000, 1'b1};

        // Outputs held at zero while reset is asserted
        step();
        step();
        checkOutput("reset result", data_result, 32'd0);
        checkOutput("reset exception", {31'd0, data_exception}, 32'd0);
        checkOutput("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);

        // Start presented on the very first edge after reset release
        resetn = 1'b1;
        for (int i = 0; i < 11; i++) begin
            runOp(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].expResult, vecs[i].expExc, 1'b1);
            step();
        end

        // Abort-and-restart at iteration 10
        $display("[TB] restart sequence");
        applyStimulus(32'd2, 32'd2);
        noPulse("restart no early pulse", 10);
        runOp("restart", 32'd4, 32'hFFFFFFFD, 32'hFFFFFFF4, 1'b0, 1'b1);
        noPulse("restart single pulse", 40);

        // Reset asserted mid-run for one cycle
        $display("[TB] reset-abort sequence");
        applyStimulus(32'd123, 32'd456);
        for (int k = 0; k < 20; k++) step();
        resetn = 1'b0;
        #1;
        checkOutput("midreset result", data_result, 32'd0);
        checkOutput("midreset exception", {31'd0, data_exception}, 32'd0);
        checkOutput("midreset rdy", {31'd0, data_resultRDY}, 32'd0);
        checkOutput("midreset busy", {31'd0, busy}, 32'd0);
        step();
        resetn = 1'b1;
        noPulse("aborted op no pulse", 40);
        runOp("9x9 after reset", 32'd9, 32'd9, 32'h00000051, 1'b0, 1'b1);

        // Back-to-back: second start issued during the DONE cycle of the first
        $display("[TB] back-to-back sequence");
        runOp("b2b first", 32'd5, 32'd7, 32'd35, 1'b0, 1'b0);
        exp = refMul(32'hFFFFFFF5, 32'd13);
        runOp("b2b second", 32'hFFFFFFF5, 32'd13, exp[31:0], exp[32], 1'b1);

        // Randomized operands against the arithmetic model
        $display("[TB] random sequence");
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 0) begin
                ra = $urandom_range(2000, 0) - 32'd1000;
                rb = $urandom_range(2000, 0) - 32'd1000;
            end else if (i % 3 == 1) begin
                rb = $urandom_range(65535, 0);
            end
            exp = refMul(ra, rb);
            runOp("random", ra, rb, exp[31:0], exp[32], 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
